video_stream_sink: RTL and testbench

VIDEO_STREAM_SINK -- requirements
Module: video_stream_sink

---
 rtl/avalon_stream_if.sv | 27 ++
 rtl/video_stream_sink.sv | 168 ++++++++++++++++
 tb/tb_video_stream_sink.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_stream_if.sv
// Avalon-ST video stream bundle: 32-bit data word with packet framing and
// a ready signal returned by the sink.
interface avalon_stream_if;
  logic [31:0] data;
  logic        valid;
  logic        startofpacket;
  logic        endofpacket;
  logic        ready;

  // Sink side: receives the stream and returns ready.
  modport agent (
    input  data,
    input  valid,
    input  startofpacket,
    input  endofpacket,
    output ready
  );

  // Source side: drives the stream and observes ready.
  modport source (
    output data,
    output valid,
    output startofpacket,
    output endofpacket,
    input  ready
  );
endinterface

// File: rtl/video_stream_sink.sv
// Avalon-ST video sink. Decodes packet headers (type nibble 0 = video data,
// anything else = control packet), turns video packets into a registered
// pixel stream with x/y coordinates and frame markers, counts complete
// frames, and flags short, long and stray packets with one-cycle pulses.
module video_stream_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 90,
  parameter int DW     = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_stream_if.agent        avalon_stream_ifa,
  input  logic                  sink_ready,
  output logic                  pix_valid,
  output logic [DW-1:0]         pix_data,
  output logic [10:0]           pix_x,
  output logic [10:0]           pix_y,
  output logic                  pix_sof,
  output logic                  pix_eof,
  output logic [15:0]           frame_count,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_stray
);

  // Coordinate counters are only as wide as the frame needs.
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  // Coordinates leave the block on 11-bit ports and pixels come from a
  // 32-bit word, so anything larger cannot be represented.
  generate
    if (WIDTH < 1 || WIDTH > 2048 || HEIGHT < 1 || HEIGHT > 2048 ||
        DW < 1 || DW > 32) begin : g_bad_params
      $error("video_stream_sink: WIDTH/HEIGHT must be 1..2048 and DW 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CTRL, DATA, DROP} state_t;

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [15:0]     frame_count_q;
  logic            pix_valid_q;
  logic [DW-1:0]   pix_data_q;
  logic [10:0]     pix_x_q;
  logic [10:0]     pix_y_q;
  logic            pix_sof_q;
  logic            pix_eof_q;
  logic            err_short_q;
  logic            err_long_q;
  logic            err_stray_q;

  logic            xfer;
  logic            sop;
  logic            eop;
  logic [31:0]     word;
  logic            last_pix;
  logic            unused_data_bits;

  // Zero-latency backpressure: the upstream sees downstream readiness directly.
  assign avalon_stream_ifa.ready = sink_ready;

  assign xfer     = avalon_stream_ifa.valid && sink_ready;
  assign sop      = avalon_stream_ifa.startofpacket;
  assign eop      = avalon_stream_ifa.endofpacket;
  assign word     = avalon_stream_ifa.data;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  // Bits above the pixel field and above the header nibble carry nothing here.
  assign unused_data_bits = ^word;

  // Packet FSM, coordinate counters, frame counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_sof_q     <= 1'b0;
      pix_eof_q     <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      // Strobes and error flags are single-cycle pulses.
      pix_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_stray_q <= 1'b0;

      if (xfer) begin
        if (sop) begin
          // A new header always wins: abandon whatever was in progress.
          err_short_q <= (state_q == DATA);
          x_q         <= '0;
          y_q         <= '0;
          if (eop) begin
            state_q <= IDLE;
          end else if (word[3:0] == 4'h0) begin
            state_q <= DATA;
          end else begin
            state_q <= CTRL;
          end
        end else begin
          case (state_q)
            IDLE: begin
              err_stray_q <= 1'b1;
            end
            CTRL, DROP: begin
              if (eop) state_q <= IDLE;
            end
            DATA: begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= word[DW-1:0];
              pix_x_q     <= 11'(x_q);
              pix_y_q     <= 11'(y_q);
              pix_sof_q   <= (x_q == '0) && (y_q == '0);
              pix_eof_q   <= last_pix;
              if (last_pix) begin
                x_q <= '0;
                y_q <= '0;
                if (eop) begin
                  frame_count_q <= frame_count_q + 16'd1;
                  state_q       <= IDLE;
                end else begin
                  // Frame is full but the packet keeps going: swallow the rest.
                  err_long_q <= 1'b1;
                  state_q    <= DROP;
                end
              end else if (eop) begin
                err_short_q <= 1'b1;
                x_q         <= '0;
                y_q         <= '0;
                state_q     <= IDLE;
              end else if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eof     = pix_eof_q;
  assign frame_count = frame_count_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_video_stream_sink.sv
// Self-checking bench for video_stream_sink. Expected pixel outputs are
// derived from the packet layout (pixel index -> x = i % W, y = i / W) and
// the frame/packet-length rules, independent of the RTL's internals.
module tb_video_stream_sink;
  localparam int W  = 160;
  localparam int H  = 90;
  localparam int DW = 24;
  localparam int F  = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sink_ready = 1'b1;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [10:0]   pix_x;
  logic [10:0]   pix_y;
  logic          pix_sof;
  logic          pix_eof;
  logic [15:0]   frame_count;
  logic          err_short;
  logic          err_long;
  logic          err_stray;

  avalon_stream_if av ();

  video_stream_sink #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .avalon_stream_ifa (av),
    .sink_ready        (sink_ready),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_x             (pix_x),
    .pix_y             (pix_y),
    .pix_sof           (pix_sof),
    .pix_eof           (pix_eof),
    .frame_count       (frame_count),
    .err_short         (err_short),
    .err_long          (err_long),
    .err_stray         (err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            pv;
    logic [DW-1:0] d;
    int            x;
    int            y;
    bit            sof;
    bit            eof;
    bit            es;
    bit            el;
    bit            est;
  } exp_t;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_fc   = 0;
  bit stall_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t quiet();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic check_outputs(input exp_t e);
    chk("pix_valid", 32'(pix_valid), 32'(e.pv));
    chk("err_short", 32'(err_short), 32'(e.es));
    chk("err_long", 32'(err_long), 32'(e.el));
    chk("err_stray", 32'(err_stray), 32'(e.est));
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    if (e.pv) begin
      chk("pix_data", 32'(pix_data), 32'(e.d));
      chk("pix_x", 32'(pix_x), e.x);
      chk("pix_y", 32'(pix_y), e.y);
      chk("pix_sof", 32'(pix_sof), 32'(e.sof));
      chk("pix_eof", 32'(pix_eof), 32'(e.eof));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_sof"}, 32'(pix_sof), 32'd0);
    chk({tag, "_eof"}, 32'(pix_eof), 32'd0);
    chk({tag, "_fc"}, 32'(frame_count), 32'd0);
    chk({tag, "_errs"}, 32'({err_short, err_long, err_stray}), 32'd0);
  endtask

  // Offer one word until it is accepted; check the outputs after every edge.
  task automatic send_word(input logic [31:0] d, input bit sop, input bit eop, input exp_t e);
    int waits;
    bit done;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      av.data          = d;
      av.startofpacket = sop;
      av.endofpacket   = eop;
      av.valid         = !(stall_en && (cyc % 23) >= 20);
      sink_ready       = !(stall_en && ((cyc + 7) % 23) < 3);
      #1;
      chk("ready_follow", 32'(av.ready), 32'(sink_ready));
      @(posedge clk);
      cyc++;
      #1;
      if (av.valid && sink_ready) begin
        done = 1'b1;
        check_outputs(e);
      end else begin
        check_outputs(quiet());
        waits++;
        if (waits > 50) begin
          n_fail++;
          $display("FAIL handshake_timeout observed=no transfer required=transfer within 50 cycles");
          $fatal(1, "handshake stuck");
        end
      end
    end
    av.valid = 1'b0;
  endtask

  // Pixels [from, upto) of a video packet that is n pixels long in total.
  task automatic send_pixels(input int from, input int upto, input int n);
    exp_t        e;
    logic [31:0] w;
    bit          eop;
    for (int i = from; i < upto; i++) begin
      e   = quiet();
      w   = $urandom;
      eop = (i == n - 1);
      if (i < F) begin
        e.pv  = 1'b1;
        e.d   = w[DW-1:0];
        e.x   = i % W;
        e.y   = i / W;
        e.sof = (i == 0);
        e.eof = (i == F - 1);
      end
      e.es = eop && (n < F);
      e.el = (i == F - 1) && (n > F);
      if (eop && n == F) exp_fc = (exp_fc + 1) % 65536;
      send_word(w, 1'b0, eop, e);
    end
  endtask

  task automatic send_header(input logic [31:0] d, input bit eop, input bit abandons_data);
    exp_t e;
    e    = quiet();
    e.es = abandons_data;
    send_word(d, 1'b1, eop, e);
  endtask

  task automatic send_stray();
    exp_t e;
    e     = quiet();
    e.est = 1'b1;
    send_word($urandom, 1'b0, 1'b0, e);
  endtask

  task automatic send_ctrl_packet();
    send_header(32'h0000_000F, 1'b0, 1'b0);
    send_word(32'h1111_1111, 1'b0, 1'b0, quiet());
    send_word(32'h2222_2222, 1'b0, 1'b0, quiet());
    send_word(32'h3333_3333, 1'b0, 1'b1, quiet());
  endtask

  initial begin
    int k;
    int m;
    av.valid = 1'b0;
    av.data = '0;
    av.startofpacket = 1'b0;
    av.endofpacket = 1'b0;

    // Reset: outputs zero, ready still follows sink_ready, transfers ignored.
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    sink_ready = 1'b0;
    #1;
    chk("ready_in_reset_lo", 32'(av.ready), 32'd0);
    sink_ready = 1'b1;
    av.valid = 1'b1;
    av.startofpacket = 1'b1;
    av.data = 32'h0000_0040;
    #1;
    chk("ready_in_reset_hi", 32'(av.ready), 32'd1);
    @(posedge clk);
    #1;
    check_zero("xfer_in_reset");
    av.valid = 1'b0;
    av.startofpacket = 1'b0;
    reset = 1'b1;
    $display("step: reset released");

    // Control packet then a full frame, no backpressure.
    send_ctrl_packet();
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, F, F);
    $display("step: ctrl + full frame, frame_count=%0d", frame_count);

    // Same stream with periodic ready drops and valid stalls.
    stall_en = 1'b1;
    send_ctrl_packet();
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, F, F);
    stall_en = 1'b0;
    $display("step: stalled full frame, frame_count=%0d cycles=%0d", frame_count, cyc);

    // Empty packet returns to idle silently; a following headerless word is stray.
    send_header(32'h0000_0040, 1'b1, 1'b0);
    send_stray();
    $display("step: empty packet then stray word");

    // Short packet: end of packet on pixel 100.
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, 101, 101);
    $display("step: short packet of 101 pixels");

    // Long packet: two extra pixels after the frame is full.
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, F + 2, F + 2);
    $display("step: long packet of %0d pixels", F + 2);

    // Stray words in idle, then a frame abandoned by a new header.
    k = $urandom_range(5, 2);
    for (int i = 0; i < k; i++) send_stray();
    m = $urandom_range(300, 50);
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, m, F);
    send_header(32'h4444_4440, 1'b0, 1'b1);
    send_pixels(0, F, F);
    $display("step: %0d stray words, frame abandoned at %0d, restarted frame", k, m);

    // Reset in the middle of a frame.
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, 5000, F);
    av.data = $urandom;
    av.valid = 1'b1;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("reset_hold1");
    @(posedge clk);
    #1;
    check_zero("reset_hold2");
    av.valid = 1'b0;
    reset = 1'b1;
    exp_fc = 0;
    send_stray();
    send_stray();
    send_header(32'h4444_4440, 1'b0, 1'b0);
    send_pixels(0, F, F);
    $display("step: mid-frame reset then full frame, frame_count=%0d", frame_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=still running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
